// File: rtl/r2r_adc_pkg.sv
// Shared types, default sizing and channel-search helper for the R2R SAR ADC controller.
package r2r_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUX_SETTLE,
        TRIAL,
        RESULT,
        NEXT
    } state_e;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_SETTLE_CYCLES = 50000;

    // Upper bound on CHANNELS supported by the search helper.
    localparam int MAX_CH = 64;

    // Lowest set bit of mask at index >= from, or -1 when none remains.
    function automatic int next_set(input logic [MAX_CH-1:0] mask, input int from);
        next_set = -1;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && i >= from) next_set = i;
        end
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Load/count/done timer: done_o rises SETTLE_CYCLES cycles after load_i, including the load cycle's successor.
module settle_timer #(
    parameter  int SETTLE_CYCLES = 1,
    localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)            cnt_q <= '0;
        else if (load_i)        cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
        else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/r2r_sar_adc_mc.sv
// Multi-channel SAR ADC controller for an R-2R ladder and analog input mux.
// Define R2R_SAR_AVG_EN to average 2^AVG_LOG2 back-to-back conversions per channel.
module r2r_sar_adc_mc
    import r2r_adc_pkg::*;
#(
    parameter  int WIDTH         = DEF_WIDTH,
    parameter  int CHANNELS      = DEF_CHANNELS,
    parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter  int AVG_LOG2      = 2,
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic [CHANNELS-1:0] ch_enable_i,
    input  logic                comp_in_i,
    output logic [CH_W-1:0]     ch_sel_o,
    output logic [WIDTH-1:0]    r2r_bus_o,
    output logic                busy_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [WIDTH-1:0]    res_code_o,
    output logic [CH_W-1:0]     res_ch_o,
    output logic                scan_done_o
);

    localparam int BIT_W = $clog2(WIDTH);

    state_e              state_q, state_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [WIDTH-1:0]    code_q, code_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                tmr_load, tmr_done;
    logic [WIDTH-1:0]    trial_code, kept_code;
    int                  nxt_ch, first_ch;

`ifdef R2R_SAR_AVG_EN
    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SMP_W-1:0] smp_q, smp_d;
`endif

    function automatic logic [MAX_CH-1:0] widen(input logic [CHANNELS-1:0] m);
        widen = '0;
        widen[CHANNELS-1:0] = m;
    endfunction

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (tmr_load),
        .done_o  (tmr_done)
    );

    assign trial_code = code_q | (WIDTH'(1) << bit_q);
    assign kept_code  = comp_in_i ? trial_code : code_q;
    assign nxt_ch     = next_set(widen(mask_q), int'(ch_q) + 1);
    assign first_ch   = next_set(widen(ch_enable_i), 0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            code_q  <= '0;
            bit_q   <= '0;
`ifdef R2R_SAR_AVG_EN
            acc_q   <= '0;
            smp_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            code_q  <= code_d;
            bit_q   <= bit_d;
`ifdef R2R_SAR_AVG_EN
            acc_q   <= acc_d;
            smp_q   <= smp_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        code_d   = code_q;
        bit_d    = bit_q;
        tmr_load = 1'b0;
`ifdef R2R_SAR_AVG_EN
        acc_d    = acc_q;
        smp_d    = smp_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i && (ch_enable_i != '0)) begin
                    mask_d   = ch_enable_i;
                    ch_d     = CH_W'(first_ch);
                    state_d  = MUX_SETTLE;
                    tmr_load = 1'b1;
                end
            end
            MUX_SETTLE: begin
                if (tmr_done) begin
                    state_d  = TRIAL;
                    bit_d    = BIT_W'(WIDTH - 1);
                    code_d   = '0;
                    tmr_load = 1'b1;
`ifdef R2R_SAR_AVG_EN
                    acc_d    = '0;
                    smp_d    = '0;
`endif
                end
            end
            TRIAL: begin
                if (tmr_done) begin
                    code_d = kept_code;
                    if (bit_q != '0) begin
                        bit_d    = bit_q - 1'b1;
                        tmr_load = 1'b1;
                    end else begin
`ifdef R2R_SAR_AVG_EN
                        acc_d = acc_q + ACC_W'(kept_code);
                        if (smp_q == SMP_W'((1 << AVG_LOG2) - 1)) begin
                            state_d = RESULT;
                        end else begin
                            // Next sample restarts the search without another mux settle.
                            smp_d    = smp_q + 1'b1;
                            bit_d    = BIT_W'(WIDTH - 1);
                            code_d   = '0;
                            tmr_load = 1'b1;
                        end
`else
                        state_d = RESULT;
`endif
                    end
                end
            end
            RESULT: begin
                if (res_ready_i) state_d = NEXT;
            end
            NEXT: begin
                if (nxt_ch >= 0) begin
                    ch_d     = CH_W'(nxt_ch);
                    state_d  = MUX_SETTLE;
                    tmr_load = 1'b1;
                end else if (cont_i && (ch_enable_i != '0)) begin
                    mask_d   = ch_enable_i;
                    ch_d     = CH_W'(first_ch);
                    state_d  = MUX_SETTLE;
                    tmr_load = 1'b1;
                end else begin
                    if (cont_i) mask_d = ch_enable_i;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_sel_o    = ch_q;
        busy_o      = (state_q != IDLE);
        res_valid_o = (state_q == RESULT);
        scan_done_o = (state_q == NEXT) && (nxt_ch < 0);
        r2r_bus_o   = '0;
        res_code_o  = '0;
        res_ch_o    = '0;
        case (state_q)
            TRIAL:  r2r_bus_o = trial_code;
            RESULT: begin
                r2r_bus_o = code_q;
                res_ch_o  = ch_q;
`ifdef R2R_SAR_AVG_EN
                res_code_o = WIDTH'(acc_q >> AVG_LOG2);
`else
                res_code_o = code_q;
`endif
            end
            default: ;
        endcase
    end

endmodule
